// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory loader.
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_BYTES = XLEN / BYTE_W;

  // Loader FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StChk,
    StDone,
    StErr
  } ld_state_e;

  // Byte address of instruction word idx, relative to base.
  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] base,
                                                input logic [XLEN-1:0] idx);
    return base + {idx[XLEN-3:0], 2'b00};
  endfunction

endpackage

// File: rtl/inst_mem_loader.sv
// Program loader: frames a byte stream (length, words, checksum) into 32-bit
// instruction-memory writes and holds the core in reset while loading.
module inst_mem_loader
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned     MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [XLEN-1:0]   wr_addr,
  output logic [XLEN-1:0]   wr_data,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err
);

  ld_state_e                  state_q, state_d;
  logic [1:0]                 cnt_q, cnt_d;
  // Holds the three most recent bytes; the incoming byte completes a word.
  logic [XLEN-BYTE_W-1:0]     shift_q, shift_d;
  logic [XLEN-1:0]            len_q, len_d;
  logic [XLEN-1:0]            idx_q, idx_d;
  logic [BYTE_W-1:0]          chk_q, chk_d;
  logic                       wr_en_q, wr_en_d;
  logic [XLEN-1:0]            wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]            wr_data_q, wr_data_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;

  logic                       accept;
  logic [XLEN-1:0]            asm_word;

  // Ready is a function of state only, so it never loops back through byte_valid.
  always_comb begin
    byte_ready = (state_q == StLen) || (state_q == StData) || (state_q == StChk);
  end

  assign accept   = byte_valid && byte_ready;
  assign asm_word = {byte_data, shift_q};

  // Next-state logic for the FSM and byte assembler.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    len_d     = len_q;
    idx_d     = idx_q;
    chk_d     = chk_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    err_d     = err_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StLen;
          cnt_d   = 2'd0;
          idx_d   = '0;
          chk_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      StLen: begin
        if (accept) begin
          shift_d = asm_word[XLEN-1:BYTE_W];
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            len_d = asm_word;
            if (asm_word > XLEN'(MAX_WORDS)) begin
              state_d = StErr;
              err_d   = 1'b1;
            end else if (asm_word == '0) begin
              state_d = StChk;
            end else begin
              state_d = StData;
            end
          end
        end
      end
      StData: begin
        if (accept) begin
          shift_d = asm_word[XLEN-1:BYTE_W];
          cnt_d   = cnt_q + 2'd1;
          chk_d   = chk_q ^ byte_data;
          if (cnt_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_data_d = asm_word;
            wr_addr_d = word_addr(BASE_ADDR, idx_q);
            idx_d     = idx_q + 1'b1;
            if (idx_q + 1'b1 == len_q) begin
              state_d = StChk;
            end
          end
        end
      end
      StChk: begin
        if (accept) begin
          if (byte_data == chk_q) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 2'd0;
      shift_q   <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      chk_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= BASE_ADDR;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      chk_q     <= chk_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // The final word's strobe lands after the state has left DATA; keep the core held through it.
  always_comb begin
    core_hold = byte_ready || wr_en_q;
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule
